// File: rtl/adc_sample_fifo_pkg.sv
// Shared constants, batch FSM state type and test-pattern frames for adc_sample_fifo.
package adc_pkg;

    localparam int NUM_CHANNELS    = 8;
    localparam int BITS_PER_SAMPLE = 16;
    localparam int SAMPLE_WIDTH    = NUM_CHANNELS * BITS_PER_SAMPLE;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ANNOUNCE = 2'd1,
        SEND     = 2'd2
    } batch_state_t;

    // Channel k carries (k+1)*10, or its two's-complement negation.
    function automatic logic [SAMPLE_WIDTH-1:0] make_pattern(input logic negate);
        logic [SAMPLE_WIDTH-1:0]    frame;
        logic [BITS_PER_SAMPLE-1:0] mag;
        frame = {SAMPLE_WIDTH{1'b0}};
        mag   = {BITS_PER_SAMPLE{1'b0}};
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            mag = mag + BITS_PER_SAMPLE'(4'd10);
            frame[k*BITS_PER_SAMPLE +: BITS_PER_SAMPLE] = negate ? (~mag + BITS_PER_SAMPLE'(1'b1)) : mag;
        end
        return frame;
    endfunction

    localparam logic [SAMPLE_WIDTH-1:0] PATTERN_A = make_pattern(1'b0);
    localparam logic [SAMPLE_WIDTH-1:0] PATTERN_B = make_pattern(1'b1);

endpackage

// File: rtl/adc_sample_fifo_if.sv
// Frame push/pop bus between the ADC capture side, the FIFO and the SPI side.
interface adc_sample_fifo_if #(
    parameter int DEPTH = 128
) ();
    import adc_pkg::*;

    localparam int COUNT_W = $clog2(DEPTH + 1);

    logic [SAMPLE_WIDTH-1:0] in_data;
    logic                    in_valid;
    logic [SAMPLE_WIDTH-1:0] out_data;
    logic                    out_ready;
    logic                    resync;
    logic [COUNT_W-1:0]      count;
    logic                    overflow;

    modport master (
        output in_data, in_valid, out_ready,
        input  out_data, resync, count, overflow
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output out_data, resync, count, overflow
    );

endinterface

// File: rtl/adc_sample_fifo_sample_ram.sv
// Simple dual-port frame RAM, one write port and one registered read port (maps to SB_RAM40_4K).
module sample_ram #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 128,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Array write and registered read; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
        rd_data <= mem_r[rd_addr];
    end

endmodule

// File: rtl/adc_sample_fifo.sv
// Frame FIFO that releases BATCH-frame batches with a resync pulse and flushes on overflow.
// Optional build macro ADC_SAMPLE_FIFO_TEST_PATTERN_EN replaces in_data with alternating A/B frames.
module adc_sample_fifo
    import adc_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int BATCH = 48
) (
    input logic               clk,
    input logic               rst,
    adc_sample_fifo_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(BATCH + 1);

    logic [AW-1:0]           wr_ptr_r;
    logic [AW-1:0]           rd_ptr_r;
    logic [CW-1:0]           count_r;
    batch_state_t            state_r;
    batch_state_t            fsm_next_s;
    batch_state_t            state_s;
    logic [BW-1:0]           batch_cnt_r;
    logic [BW-1:0]           batch_cnt_s;
    logic                    resync_r;
    logic                    overflow_r;
    logic                    rd_live_r;
    logic                    rd_live_d_r;
    logic [SAMPLE_WIDTH-1:0] wr_data_s;
    logic [SAMPLE_WIDTH-1:0] ram_q_s;

    logic full_s;
    logic empty_s;
    logic push_s;
    logic pop_s;
    logic flush_s;

    assign full_s  = (count_r == CW'(DEPTH));
    assign empty_s = (count_r == {CW{1'b0}});
    assign push_s  = bus.in_valid;
    assign pop_s   = bus.out_ready && !empty_s;
    // A push into a full FIFO with a concurrent pop is ordinary traffic, not an overflow.
    assign flush_s = push_s && full_s && !bus.out_ready;

`ifdef ADC_SAMPLE_FIFO_TEST_PATTERN_EN
    logic pat_b_r;

    // A/B alternation; the frame written by a flush is always A.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pat_b_r <= 1'b0;
        end else if (flush_s) begin
            pat_b_r <= 1'b1;
        end else if (push_s) begin
            pat_b_r <= ~pat_b_r;
        end
    end

    assign wr_data_s = (flush_s || !pat_b_r) ? PATTERN_A : PATTERN_B;
`else
    assign wr_data_s = bus.in_data;
`endif

    sample_ram #(
        .WIDTH (SAMPLE_WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push_s),
        .wr_addr (wr_ptr_r),
        .wr_data (wr_data_s),
        .rd_addr (rd_ptr_r),
        .rd_data (ram_q_s)
    );

    // Pointers and occupancy; a flush restarts the FIFO around the incoming frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (flush_s) begin
                rd_ptr_r <= wr_ptr_r;
                count_r  <= CW'(1'b1);
            end else begin
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + AW'(1'b1);
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + CW'(1'b1);
                    2'b01:   count_r <= count_r - CW'(1'b1);
                    default: count_r <= count_r;
                endcase
            end
        end
    end

    // Batch FSM next state; flush overrides whatever the batch logic wanted.
    always_comb begin
        fsm_next_s  = state_r;
        batch_cnt_s = batch_cnt_r;
        case (state_r)
            IDLE: begin
                if (count_r >= CW'(BATCH)) begin
                    fsm_next_s = ANNOUNCE;
                end else begin
                    fsm_next_s = IDLE;
                end
            end
            ANNOUNCE: begin
                batch_cnt_s = BW'(BATCH);
                fsm_next_s  = SEND;
            end
            SEND: begin
                if (pop_s && (batch_cnt_r == BW'(1'b1))) begin
                    batch_cnt_s = {BW{1'b0}};
                    fsm_next_s  = IDLE;
                end else if (pop_s) begin
                    batch_cnt_s = batch_cnt_r - BW'(1'b1);
                    fsm_next_s  = SEND;
                end else begin
                    fsm_next_s  = SEND;
                end
            end
            default: begin
                batch_cnt_s = {BW{1'b0}};
                fsm_next_s  = IDLE;
            end
        endcase
        state_s = flush_s ? IDLE : fsm_next_s;
    end

    // Batch FSM state, batch counter and the registered pulse outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            batch_cnt_r <= {BW{1'b0}};
            resync_r    <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            batch_cnt_r <= batch_cnt_s;
            resync_r    <= (state_s == ANNOUNCE);
            overflow_r  <= flush_s;
        end
    end

    // RAM output is stale until the first post-reset write has been read back.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_live_r   <= 1'b0;
            rd_live_d_r <= 1'b0;
        end else begin
            rd_live_r   <= rd_live_r | push_s;
            rd_live_d_r <= rd_live_r;
        end
    end

    assign bus.out_data = rd_live_d_r ? ram_q_s : {SAMPLE_WIDTH{1'b0}};
    assign bus.resync   = resync_r;
    assign bus.overflow = overflow_r;
    assign bus.count    = count_r;

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Randomized self-checking bench for adc_sample_fifo against a queue-based frame model.
module tb_adc_sample_fifo;
    import adc_pkg::*;

    localparam int DEPTH = 128;
    localparam int BATCH = 48;
    localparam int W     = SAMPLE_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b0;

    adc_sample_fifo_if #(.DEPTH(DEPTH)) bus ();

    adc_sample_fifo #(.DEPTH(DEPTH), .BATCH(BATCH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int resync_cnt = 0;
    int ovf_cnt = 0;
    int double_cnt = 0;
    logic prev_resync = 1'b0;

    logic [W-1:0] q[$];
    bit tp_b = 1'b0;

    // Pulse monitor
    always @(negedge clk) begin
        if (bus.resync === 1'b1) resync_cnt++;
        if (bus.overflow === 1'b1) ovf_cnt++;
        if (bus.resync === 1'b1 && prev_resync === 1'b1) double_cnt++;
        prev_resync = bus.resync;
    end

    function automatic logic [W-1:0] bench_pattern(input bit neg);
        logic [W-1:0] f;
        int v;
        f = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            v = (k + 1) * 10;
            if (neg) v = -v;
            f[k*16 +: 16] = 16'(v);
        end
        return f;
    endfunction

    function automatic logic [W-1:0] rand_frame();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [W-1:0] stored_frame(input logic [W-1:0] d, input bit flush);
`ifdef ADC_SAMPLE_FIFO_TEST_PATTERN_EN
        logic [W-1:0] r;
        if (flush) begin
            tp_b = 1'b1;
            return bench_pattern(1'b0);
        end
        r = bench_pattern(tp_b);
        tp_b = ~tp_b;
        return r;
`else
        return d;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        q.delete();
        tp_b = 1'b0;
    endtask

    task automatic do_cycle(input bit push, input bit pop, input logic [W-1:0] d);
        int sz;
        bus.in_valid  = push;
        bus.out_ready = pop;
        bus.in_data   = d;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        sz = q.size();
        if (push && sz == DEPTH && !pop) begin
            q.delete();
            q.push_back(stored_frame(d, 1'b1));
        end else begin
            if (pop && sz > 0) void'(q.pop_front());
            if (push) q.push_back(stored_frame(d, 1'b0));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_data = '0;
        tick();
        tick();
        checks++; if (bus.count !== 8'd0) $display("FAIL reset_count got=%0d exp=0", bus.count); else passes++;
        checks++; if (bus.resync !== 1'b0) $display("FAIL reset_resync got=%b exp=0", bus.resync); else passes++;
        checks++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow got=%b exp=0", bus.overflow); else passes++;
        checks++; if (bus.out_data !== '0) $display("FAIL reset_out_data got=%h exp=0", bus.out_data); else passes++;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_batch_announce();
        int base;
        base = resync_cnt;
        for (int i = 0; i < BATCH; i++) do_cycle(1'b1, 1'b0, rand_frame());
        checks++; if (bus.count !== 8'(BATCH)) $display("FAIL announce_count got=%0d exp=%0d", bus.count, BATCH); else passes++;
        checks++; if (bus.resync !== 1'b0) $display("FAIL announce_early got=%b exp=0", bus.resync); else passes++;
        idle(1);
        checks++; if (bus.resync !== 1'b1) $display("FAIL announce_timing got=%b exp=1", bus.resync); else passes++;
        idle(1);
        checks++; if (bus.resync !== 1'b0) $display("FAIL announce_width got=%b exp=0", bus.resync); else passes++;
        idle(10);
        checks++; if (resync_cnt - base !== 1) $display("FAIL announce_once got=%0d exp=1", resync_cnt - base); else passes++;
    endtask

    task automatic test_batch_drain();
        int base;
        base = resync_cnt;
        for (int i = 0; i < BATCH; i++) begin
            checks++; if (bus.out_data !== q[0]) $display("FAIL drain_data idx=%0d got=%h exp=%h", i, bus.out_data, q[0]); else passes++;
            do_cycle(1'b0, 1'b1, '0);
            idle(15);
        end
        checks++; if (bus.count !== 8'd0) $display("FAIL drain_count got=%0d exp=0", bus.count); else passes++;
        idle(5);
        checks++; if (resync_cnt !== base) $display("FAIL drain_no_resync got=%0d exp=%0d", resync_cnt - base, 0); else passes++;
    endtask

    task automatic test_overflow();
        int base_o;
        int base_r;
        logic [W-1:0] d;
        do_reset();
        base_o = ovf_cnt;
        for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 1'b0, rand_frame());
        checks++; if (bus.count !== 8'(DEPTH)) $display("FAIL ovf_fill_count got=%0d exp=%0d", bus.count, DEPTH); else passes++;
        d = rand_frame();
        do_cycle(1'b1, 1'b0, d);
        checks++; if (bus.overflow !== 1'b1) $display("FAIL ovf_pulse got=%b exp=1", bus.overflow); else passes++;
        checks++; if (bus.count !== 8'd1) $display("FAIL ovf_count got=%0d exp=1", bus.count); else passes++;
        idle(1);
        checks++; if (bus.overflow !== 1'b0) $display("FAIL ovf_width got=%b exp=0", bus.overflow); else passes++;
        checks++; if (bus.out_data !== q[0]) $display("FAIL ovf_data got=%h exp=%h", bus.out_data, q[0]); else passes++;
        base_r = resync_cnt;
        for (int i = 0; i < BATCH - 2; i++) do_cycle(1'b1, 1'b0, rand_frame());
        idle(4);
        checks++; if (resync_cnt !== base_r) $display("FAIL ovf_early_resync got=%0d exp=0", resync_cnt - base_r); else passes++;
        do_cycle(1'b1, 1'b0, rand_frame());
        idle(1);
        checks++; if (bus.resync !== 1'b1) $display("FAIL ovf_reannounce got=%b exp=1", bus.resync); else passes++;
        checks++; if (ovf_cnt - base_o !== 1) $display("FAIL ovf_pulse_count got=%0d exp=1", ovf_cnt - base_o); else passes++;
    endtask

    task automatic test_empty_and_simultaneous();
        int base_o;
        do_reset();
        base_o = ovf_cnt;
        do_cycle(1'b0, 1'b1, '0);
        checks++; if (bus.count !== 8'd0) $display("FAIL empty_pop_count got=%0d exp=0", bus.count); else passes++;
        do_cycle(1'b1, 1'b0, rand_frame());
        idle(1);
        checks++; if (bus.out_data !== q[0]) $display("FAIL empty_pop_data got=%h exp=%h", bus.out_data, q[0]); else passes++;
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0, rand_frame());
        do_cycle(1'b1, 1'b1, rand_frame());
        checks++; if (bus.count !== 8'd5) $display("FAIL simul5_count got=%0d exp=5", bus.count); else passes++;
        idle(1);
        checks++; if (bus.out_data !== q[0]) $display("FAIL simul5_data got=%h exp=%h", bus.out_data, q[0]); else passes++;
        while (q.size() < DEPTH) do_cycle(1'b1, 1'b0, rand_frame());
        do_cycle(1'b1, 1'b1, rand_frame());
        checks++; if (bus.count !== 8'(DEPTH)) $display("FAIL simulfull_count got=%0d exp=%0d", bus.count, DEPTH); else passes++;
        checks++; if (bus.overflow !== 1'b0) $display("FAIL simulfull_overflow got=%b exp=0", bus.overflow); else passes++;
        idle(1);
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.out_data !== q[0]) $display("FAIL simulfull_data idx=%0d got=%h exp=%h", i, bus.out_data, q[0]); else passes++;
            do_cycle(1'b0, 1'b1, '0);
            idle(1);
        end
        checks++; if (ovf_cnt !== base_o) $display("FAIL simul_no_overflow got=%0d exp=0", ovf_cnt - base_o); else passes++;
    endtask

    task automatic test_reset_mid_send();
        int base;
        do_reset();
        for (int i = 0; i < BATCH; i++) do_cycle(1'b1, 1'b0, rand_frame());
        idle(2);
        for (int i = 0; i < 20; i++) begin
            checks++; if (bus.out_data !== q[0]) $display("FAIL midsend_data idx=%0d got=%h exp=%h", i, bus.out_data, q[0]); else passes++;
            do_cycle(1'b0, 1'b1, '0);
            idle(1);
        end
        rst = 1'b0;
        tick();
        checks++; if (bus.count !== 8'd0) $display("FAIL midsend_rst_count got=%0d exp=0", bus.count); else passes++;
        checks++; if (bus.resync !== 1'b0) $display("FAIL midsend_rst_resync got=%b exp=0", bus.resync); else passes++;
        checks++; if (bus.out_data !== '0) $display("FAIL midsend_rst_data got=%h exp=0", bus.out_data); else passes++;
        rst = 1'b1;
        model_reset();
        base = resync_cnt;
        for (int i = 0; i < BATCH; i++) do_cycle(1'b1, 1'b0, rand_frame());
        idle(1);
        checks++; if (bus.resync !== 1'b1) $display("FAIL midsend_reannounce got=%b exp=1", bus.resync); else passes++;
        idle(4);
        checks++; if (resync_cnt - base !== 1) $display("FAIL midsend_resync_count got=%0d exp=1", resync_cnt - base); else passes++;
    endtask

    task automatic test_random_traffic();
        bit push;
        bit pop;
        bit exp_ovf;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            push = ($urandom_range(0, 99) < 70);
            pop  = ($urandom_range(0, 99) < 30);
            exp_ovf = push && !pop && (q.size() == DEPTH);
            do_cycle(push, pop, rand_frame());
            checks++; if (bus.overflow !== exp_ovf) $display("FAIL rand_overflow it=%0d got=%b exp=%b", i, bus.overflow, exp_ovf); else passes++;
            idle(1);
            checks++; if (bus.count !== 8'(q.size())) $display("FAIL rand_count it=%0d got=%0d exp=%0d", i, bus.count, q.size()); else passes++;
            if (q.size() > 0) begin
                checks++; if (bus.out_data !== q[0]) $display("FAIL rand_data it=%0d got=%h exp=%h", i, bus.out_data, q[0]); else passes++;
            end
        end
        checks++; if (double_cnt !== 0) $display("FAIL resync_double got=%0d exp=0", double_cnt); else passes++;
    endtask

`ifdef ADC_SAMPLE_FIFO_TEST_PATTERN_EN
    task automatic test_pattern();
        logic [W-1:0] b;
        do_reset();
        do_cycle(1'b1, 1'b0, rand_frame());
        do_cycle(1'b1, 1'b0, rand_frame());
        idle(1);
        checks++; if (bus.out_data !== bench_pattern(1'b0)) $display("FAIL pattern_a got=%h exp=%h", bus.out_data, bench_pattern(1'b0)); else passes++;
        do_cycle(1'b0, 1'b1, '0);
        idle(1);
        b = bus.out_data;
        checks++; if (b !== bench_pattern(1'b1)) $display("FAIL pattern_b got=%h exp=%h", b, bench_pattern(1'b1)); else passes++;
        checks++; if (b[127:112] !== 16'hFFB0) $display("FAIL pattern_b_ch7 got=%h exp=ffb0", b[127:112]); else passes++;
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_data   = '0;
        test_reset();
        test_batch_announce();
        test_batch_drain();
        test_overflow();
        test_empty_and_simultaneous();
        test_reset_mid_send();
        test_random_traffic();
`ifdef ADC_SAMPLE_FIFO_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
